regfile: RTL
============

# regfile

Architectural integer register file of the pipelined core: receiving end of the writeback-stage register-write interface (`wvalid`/`wa`/`wd`), and read-port provider for the decode stage. Holds 32 XLEN-bit registers with `x0` hardwired to zero. Forwards a same-cycle write to both read ports. Contains a pending-write scoreboard so decode can stall on operands whose producer (e.g. a load) has not yet written back.

## Interface
Parameters:
- `XLEN`, 64, data width of each register.
- `NREG`, 32, number of registers; address width is log2(`NREG`) = 5.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ra1`  in  5  read address, port 1.
- `ra2`  in  5  read address, port 2.
- `rd1`  out  XLEN  read data, port 1 (combinational).
- `rd2`  out  XLEN  read data, port 2 (combinational).
- `wvalid`  in  1  writeback write enable.
- `wa`  in  5  write address.
- `wd`  in  XLEN  write data.
- `issue_valid`  in  1  decode issues an instruction that will write `issue_dst`.
- `issue_dst`  in  5  destination register of the issued instruction.
- `flush`  in  1  pipeline flush; discards all pending-write marks.
- `busy1`  out  1  `ra1` has an outstanding write not yet visible on `rd1`.
- `busy2`  out  1  `ra2` has an outstanding write not yet visible on `rd2`.

## Operation
- Storage: `regs[0..NREG-1]`, each XLEN bits; `busy[0..NREG-1]`, 1 bit each.
- Write: when `wvalid` and `wa != 0`, `regs[wa] <= wd` at the rising edge. Writes to `x0` are dropped.
- Read: `rdN = 0` when `raN == 0`; else `wd` when `wvalid && wa == raN` (write-through bypass); else `regs[raN]`.
- Scoreboard update at each edge, in priority order:
  - `reset` or `flush`: all `busy` cleared.
  - otherwise, for each register r != 0: set if `issue_valid && issue_dst == r`; else clear if `wvalid && wa == r`; else hold.
  - Simultaneous issue and writeback to the same register: set wins (the new producer is still outstanding).
  - `busy[0]` is constant 0; issues to `x0` are ignored.
- Busy output: `busyN = busy[raN] && !(wvalid && wa == raN)` for `raN != 0`; `busyN = 0` for `raN == 0`. A write arriving this cycle satisfies the operand through the bypass path.
- Writeback to a register that is not busy is legal. It updates `regs` and leaves `busy` at 0.

## Timing
- Read latency 0: `rd1`/`rd2`/`busy1`/`busy2` are combinational in `ra*`, `wvalid`, `wa`, `wd` and current state.
- Write latency 1: `regs[wa]` holds `wd` from the cycle after the edge. The same-cycle value is visible only through the bypass.
- Issue at cycle t sets `busy`, which is visible on `busyN` from t+1.
- Reset values: all `regs` = 0 and all `busy` = 0 after the first edge with `reset` high. `rd1`, `rd2`, `busy1` and `busy2` therefore read 0 for every address.
- Reset mid-operation: `reset` overrides a concurrent `wvalid`. No register is written on a reset edge.
- `flush` does not block a concurrent `wvalid`: the data write still occurs, and all `busy` bits clear.

## Test plan
- Reset, then read all 32 addresses on both ports -> `rd1` = `rd2` = 0 and `busy1` = `busy2` = 0 everywhere.
- Write `wa`=5, `wd`=64'hDEAD_BEEF_0123_4567. In the same cycle read `ra1`=5 -> `rd1` shows the value via bypass. Next cycle with `wvalid`=0 -> `rd1` still shows the value. `ra2`=6 reads 0.
- Write `wa`=0, `wd`=64'hFFFF_FFFF_FFFF_FFFF -> next cycle `rd1` at `ra1`=0 is 0. Issue to `x0` -> `busy1` stays 0.
- Scoreboard: issue `issue_dst`=7 at cycle t -> `busy1` (ra1=7) = 1 at t+1. Writeback `wa`=7, `wd`=42 at t+3 -> `busy1` = 0 and `rd1` = 42 in t+3. `busy1` = 0 at t+4.
- Collision: `busy[9]` set; in one cycle issue `issue_dst`=9 and writeback `wa`=9, `wd`=1 -> `busy1` (ra1=9) = 1 next cycle and `rd1` = 1.
- Flush and reset: set busy on regs 3 and 4. Assert `flush` together with `wvalid` `wa`=3 `wd`=8 -> next cycle both busy bits are 0 and `regs[3]` = 8. Then assert `reset` together with `wvalid` `wa`=3 `wd`=9 -> `regs[3]` = 0 afterwards.

Source files
------------

// File: rtl/regfile.sv
// Architectural integer register file with write-through bypass and pending-write scoreboard.
// Latency: reads and busy flags are combinational (0 cycles); writes and scoreboard marks land on the next rising edge.
// Backpressure: none inside the block; decode stalls on busy1/busy2 while a producer is still outstanding.
module regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            wvalid,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_dst,
    input  logic            flush,
    output logic            busy1,
    output logic            busy2
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // A write to x0 is architecturally a no-op, so it never qualifies for storage or bypass.
    logic wr_en;
    assign wr_en = wvalid && (wa != '0);

    // Register storage: reset wins over any concurrent writeback; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Scoreboard next state: a new issue outranks a retiring writeback to the same register.
    always_comb begin
        busy_nxt = '0;
        if (!(reset || flush)) begin
            for (int r = 1; r < NREG; r++) begin
                if (issue_valid && (issue_dst == AW'(r))) begin
                    busy_nxt[r] = 1'b1;
                end else if (wvalid && (wa == AW'(r))) begin
                    busy_nxt[r] = 1'b0;
                end else begin
                    busy_nxt[r] = busy[r];
                end
            end
        end
    end

    // Scoreboard register; bit 0 is always computed as 0.
    always_ff @(posedge clk) begin
        busy <= busy_nxt;
    end

    // Read port 1: x0 forced to zero, same-cycle write forwarded, otherwise stored value.
    always_comb begin
        rd1   = '0;
        busy1 = 1'b0;
        if (ra1 != '0) begin
            if (wr_en && (wa == ra1)) begin
                rd1   = wd;
                busy1 = 1'b0;
            end else begin
                rd1   = regs[ra1];
                busy1 = busy[ra1];
            end
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin
        rd2   = '0;
        busy2 = 1'b0;
        if (ra2 != '0) begin
            if (wr_en && (wa == ra2)) begin
                rd2   = wd;
                busy2 = 1'b0;
            end else begin
                rd2   = regs[ra2];
                busy2 = busy[ra2];
            end
        end
    end

endmodule
